// File: rtl/sm_keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, debounces one key, emits a hex code and shifts it into a 32-bit value.
// Optional auto-repeat while a key is held is enabled by defining SM_KEYPAD_REPEAT_EN.
module sm_keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_SCANS = 64
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic [3:0]  rows,
    input  logic        clrValue,
    output logic [3:0]  cols,
    output logic [3:0]  keyCode,
    output logic        keyValid,
    output logic        keyPressed,
    output logic [31:0] value
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_SCANS < 1) begin : g_bad_param
        $error("sm_keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [3:0]         rows_meta;
    logic [3:0]         rows_s;
    logic [TICK_W-1:0]  tick;
    logic [1:0]         col;
    logic [1:0]         col_nx;
    logic [1:0]         row;
    logic [1:0]         row_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [1:0]         first_low;
    logic               sample;
    logic               key_low;
    logic               accept;
    logic               repeat_fire;

    assign sample     = (tick == TICK_W'(SCAN_DIV - 1));
    assign key_low    = ~rows_s[row];
    assign cols       = ~(4'b0001 << col);
    assign keyPressed = (state == HELD);

    // Lowest-numbered active row wins when several keys share the strobed column.
    always_comb begin
        first_low = 2'd3;
        if (!rows_s[0]) begin
            first_low = 2'd0;
        end else if (!rows_s[1]) begin
            first_low = 2'd1;
        end else if (!rows_s[2]) begin
            first_low = 2'd2;
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        cnt_nx   = cnt;
        accept   = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (rows_s != 4'hF) begin
                        row_nx = first_low;
                        if (DEBOUNCE_CNT == 1) begin
                            state_nx = HELD;
                            cnt_nx   = '0;
                            accept   = 1'b1;
                        end else begin
                            state_nx = DEBOUNCE;
                            cnt_nx   = CNT_W'(1);
                        end
                    end else begin
                        col_nx = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (key_low) begin
                        if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                            state_nx = HELD;
                            cnt_nx   = '0;
                            accept   = 1'b1;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nx = SCAN;
                        col_nx   = col + 2'd1;
                        cnt_nx   = '0;
                    end
                end
                HELD: begin
                    // In HELD the counter tracks consecutive release samples.
                    if (key_low) begin
                        cnt_nx = '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        state_nx = SCAN;
                        col_nx   = col + 2'd1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = SCAN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

`ifdef SM_KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);

    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_nx;

    always_comb begin
        rep_nx      = rep;
        repeat_fire = 1'b0;
        if (state_nx == HELD && state != HELD) begin
            rep_nx = '0;
        end else if (sample && state == HELD) begin
            if (!key_low) begin
                rep_nx = '0;
            end else if (rep == REP_W'(REPEAT_SCANS - 1)) begin
                rep_nx      = '0;
                repeat_fire = 1'b1;
            end else begin
                rep_nx = rep + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            rep <= '0;
        end else begin
            rep <= rep_nx;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta <= 4'hF;
            rows_s    <= 4'hF;
            tick      <= '0;
            state     <= SCAN;
            col       <= 2'd0;
            row       <= 2'd0;
            cnt       <= '0;
            keyCode   <= 4'h0;
            keyValid  <= 1'b0;
            value     <= 32'h0;
        end else begin
            rows_meta <= rows;
            rows_s    <= rows_meta;
            tick      <= sample ? '0 : tick + TICK_W'(1);
            state     <= state_nx;
            col       <= col_nx;
            row       <= row_nx;
            cnt       <= cnt_nx;
            keyValid  <= accept | repeat_fire;
            if (accept) begin
                keyCode <= {row_nx, col};
            end
            // A clear in the same cycle as a strobe discards that digit.
            if (clrValue) begin
                value <= 32'h0;
            end else if (keyValid) begin
                value <= {value[27:0], keyCode};
            end
        end
    end

endmodule

// File: tb/tb_sm_keypad_scanner.sv
// Self-checking bench for sm_keypad_scanner: a keypad model answers the column strobes, and
// expected codes/values come from a digit-level model of key presses.
module tb_sm_keypad_scanner;

    logic        clkIn = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows;
    logic        clrValue = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyPressed;
    logic [31:0] value;

    logic [15:0] keys = 16'h0;
    logic        force_en = 1'b0;
    logic [3:0]  force_val = 4'hF;

    int n_compared = 0;
    int n_mismatched = 0;
    int kv_count = 0;
    int kv_double = 0;
    logic kv_prev = 1'b0;

    sm_keypad_scanner dut (
        .clkIn      (clkIn),
        .rst_n      (rst_n),
        .rows       (rows),
        .clrValue   (clrValue),
        .cols       (cols),
        .keyCode    (keyCode),
        .keyValid   (keyValid),
        .keyPressed (keyPressed),
        .value      (value)
    );

    always #5 clkIn = ~clkIn;

    // Key (r,c) is bit r*4+c, which is also its hex code; it pulls row r low while column c is strobed.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && cols[c] == 1'b0) rows[r] = 1'b0;
            end
        end
        if (force_en) rows = force_val;
    end

    always @(negedge clkIn) begin
        if (keyValid === 1'b1) begin
            kv_count <= kv_count + 1;
            if (kv_prev) kv_double <= kv_double + 1;
        end
        kv_prev <= (keyValid === 1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic do_reset();
        @(negedge clkIn);
        keys = 16'h0;
        clrValue = 1'b0;
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [4];
        logic [3:0] prev;
        int k;
        int last;
        int bad_onehot;
        exp_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        force_en = 1'b1;
        force_val = 4'h0;
        @(negedge clkIn);
        rst_n = 1'b0;
        #1;
        n_compared++; if (cols !== 4'b1110) begin n_mismatched++; $display("[TB] FAIL reset_cols: got %b expected 1110", cols); end
        n_compared++; if (keyCode !== 4'h0) begin n_mismatched++; $display("[TB] FAIL reset_keyCode: got %h expected 0", keyCode); end
        n_compared++; if (keyValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_keyValid: got %b expected 0", keyValid); end
        n_compared++; if (keyPressed !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_keyPressed: got %b expected 0", keyPressed); end
        n_compared++; if (value !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_value: got %h expected 0", value); end
        cycles(4);
        force_val = 4'hF;
        rst_n = 1'b1;
        prev = cols;
        k = 0;
        last = 0;
        bad_onehot = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clkIn);
            if ($countones(~cols) != 1) bad_onehot++;
            if (cols !== prev) begin
                if (k < 4) begin
                    n_compared++; if (cols !== exp_seq[k]) begin n_mismatched++; $display("[TB] FAIL walk_cols[%0d]: got %b expected %b", k, cols, exp_seq[k]); end
                    n_compared++; if (i - last != 16) begin n_mismatched++; $display("[TB] FAIL walk_period[%0d]: got %0d expected 16", k, i - last); end
                end
                k++;
                last = i;
                prev = cols;
            end
        end
        n_compared++; if (k != 4) begin n_mismatched++; $display("[TB] FAIL walk_changes: got %0d expected 4", k); end
        n_compared++; if (bad_onehot != 0) begin n_mismatched++; $display("[TB] FAIL walk_onehot: got %0d bad cycles expected 0", bad_onehot); end
        force_en = 1'b0;
    endtask

    task automatic test_single_press();
        int base;
        do_reset();
        base = kv_count;
        keys[9] = 1'b1;
        cycles(200);
        n_compared++; if (kv_count - base != 1) begin n_mismatched++; $display("[TB] FAIL single_strobes: got %0d expected 1", kv_count - base); end
        n_compared++; if (keyCode !== 4'h9) begin n_mismatched++; $display("[TB] FAIL single_keyCode: got %h expected 9", keyCode); end
        n_compared++; if (value !== 32'h9) begin n_mismatched++; $display("[TB] FAIL single_value: got %h expected 9", value); end
        n_compared++; if (keyPressed !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_held: got %b expected 1", keyPressed); end
        keys[9] = 1'b0;
        cycles(20);
        n_compared++; if (keyPressed !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_release_early: got %b expected 1", keyPressed); end
        cycles(130);
        n_compared++; if (keyPressed !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_released: got %b expected 0", keyPressed); end
        n_compared++; if (kv_count - base != 1) begin n_mismatched++; $display("[TB] FAIL single_after_release: got %0d expected 1", kv_count - base); end
    endtask

    task automatic test_bounce();
        int base;
        do_reset();
        base = kv_count;
        for (int i = 0; i < 12; i++) begin
            keys[9] = 1'b1;
            cycles(10);
            keys[9] = 1'b0;
            cycles(10);
        end
        n_compared++; if (kv_count - base != 0) begin n_mismatched++; $display("[TB] FAIL bounce_press: got %0d expected 0", kv_count - base); end
        keys[9] = 1'b1;
        cycles(200);
        n_compared++; if (kv_count - base != 1) begin n_mismatched++; $display("[TB] FAIL bounce_stable: got %0d expected 1", kv_count - base); end
        n_compared++; if (keyCode !== 4'h9) begin n_mismatched++; $display("[TB] FAIL bounce_keyCode: got %h expected 9", keyCode); end
        for (int i = 0; i < 12; i++) begin
            keys[9] = 1'b0;
            cycles(10);
            keys[9] = 1'b1;
            cycles(10);
        end
        n_compared++; if (keyPressed !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bounce_release_held: got %b expected 1", keyPressed); end
        keys[9] = 1'b0;
        cycles(150);
        n_compared++; if (kv_count - base != 1) begin n_mismatched++; $display("[TB] FAIL bounce_release: got %0d expected 1", kv_count - base); end
        n_compared++; if (keyPressed !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bounce_released: got %b expected 0", keyPressed); end
    endtask

    task automatic test_digit_entry();
        int base;
        int waited;
        do_reset();
        base = kv_count;
        for (int d = 1; d <= 9; d++) begin
            keys = 16'(1) << d;
            cycles(200);
            keys = 16'h0;
            cycles(150);
        end
        n_compared++; if (kv_count - base != 9) begin n_mismatched++; $display("[TB] FAIL digits_strobes: got %0d expected 9", kv_count - base); end
        n_compared++; if (value !== 32'h23456789) begin n_mismatched++; $display("[TB] FAIL digits_value: got %h expected 23456789", value); end
        keys = 16'(1) << 5;
        waited = 0;
        while (keyValid !== 1'b1 && waited < 300) begin
            @(negedge clkIn);
            waited++;
        end
        n_compared++; if (waited >= 300) begin n_mismatched++; $display("[TB] FAIL clear_wait: got timeout expected keyValid within 300 cycles"); end
        clrValue = 1'b1;
        cycles(1);
        clrValue = 1'b0;
        n_compared++; if (value !== 32'h0) begin n_mismatched++; $display("[TB] FAIL clear_wins: got %h expected 0", value); end
        n_compared++; if (keyCode !== 4'h5) begin n_mismatched++; $display("[TB] FAIL clear_keyCode: got %h expected 5", keyCode); end
        keys = 16'h0;
        cycles(150);
        n_compared++; if (value !== 32'h0) begin n_mismatched++; $display("[TB] FAIL clear_stays: got %h expected 0", value); end
    endtask

    task automatic test_multi_key();
        int base;
        do_reset();
        base = kv_count;
        keys = (16'(1) << 4) | (16'(1) << 12);
        cycles(200);
        n_compared++; if (kv_count - base != 1) begin n_mismatched++; $display("[TB] FAIL multi_strobes: got %0d expected 1", kv_count - base); end
        n_compared++; if (keyCode !== 4'h4) begin n_mismatched++; $display("[TB] FAIL multi_keyCode: got %h expected 4", keyCode); end
        keys = keys | (16'(1) << 2);
        cycles(200);
        n_compared++; if (kv_count - base != 1) begin n_mismatched++; $display("[TB] FAIL multi_extra: got %0d expected 1", kv_count - base); end
        n_compared++; if (keyPressed !== 1'b1) begin n_mismatched++; $display("[TB] FAIL multi_held: got %b expected 1", keyPressed); end
        keys = 16'h0;
        cycles(150);
        n_compared++; if (keyPressed !== 1'b0) begin n_mismatched++; $display("[TB] FAIL multi_released: got %b expected 0", keyPressed); end
        n_compared++; if (value !== 32'h4) begin n_mismatched++; $display("[TB] FAIL multi_value: got %h expected 4", value); end
    endtask

    task automatic test_reset_mid_debounce();
        int base;
        @(negedge clkIn);
        rst_n = 1'b0;
        keys = 16'h1;
        cycles(2);
        rst_n = 1'b1;
        base = kv_count;
        cycles(40);
        rst_n = 1'b0;
        #1;
        n_compared++; if (cols !== 4'b1110) begin n_mismatched++; $display("[TB] FAIL middeb_cols: got %b expected 1110", cols); end
        n_compared++; if (keyPressed !== 1'b0) begin n_mismatched++; $display("[TB] FAIL middeb_pressed: got %b expected 0", keyPressed); end
        keys = 16'h0;
        cycles(2);
        rst_n = 1'b1;
        cycles(150);
        n_compared++; if (kv_count - base != 0) begin n_mismatched++; $display("[TB] FAIL middeb_strobes: got %0d expected 0", kv_count - base); end
        n_compared++; if (value !== 32'h0) begin n_mismatched++; $display("[TB] FAIL middeb_value: got %h expected 0", value); end
    endtask

    task automatic test_random();
        logic [31:0] model;
        int base;
        int code;
        do_reset();
        model = 32'h0;
        for (int n = 0; n < 12; n++) begin
            code = $urandom_range(0, 15);
            base = kv_count;
            keys = 16'(1) << code;
            cycles($urandom_range(180, 260));
            model = {model[27:0], 4'(code)};
            n_compared++; if (kv_count - base != 1) begin n_mismatched++; $display("[TB] FAIL rand_strobes[%0d]: got %0d expected 1", n, kv_count - base); end
            n_compared++; if (keyCode !== 4'(code)) begin n_mismatched++; $display("[TB] FAIL rand_keyCode[%0d]: got %h expected %h", n, keyCode, 4'(code)); end
            n_compared++; if (value !== model) begin n_mismatched++; $display("[TB] FAIL rand_value[%0d]: got %h expected %h", n, value, model); end
            keys = 16'h0;
            cycles($urandom_range(130, 200));
            n_compared++; if (keyPressed !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rand_release[%0d]: got %b expected 0", n, keyPressed); end
            if ($urandom_range(0, 3) == 0) begin
                clrValue = 1'b1;
                cycles(1);
                clrValue = 1'b0;
                model = 32'h0;
                n_compared++; if (value !== model) begin n_mismatched++; $display("[TB] FAIL rand_clear[%0d]: got %h expected 0", n, value); end
            end
        end
    endtask

`ifdef SM_KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int base;
        int waited;
        do_reset();
        keys = 16'h1;
        waited = 0;
        while (keyValid !== 1'b1 && waited < 300) begin
            @(negedge clkIn);
            waited++;
        end
        n_compared++; if (waited >= 300) begin n_mismatched++; $display("[TB] FAIL repeat_wait: got timeout expected keyValid within 300 cycles"); end
        cycles(1);
        base = kv_count;
        cycles(2 * 64 * 16 + 8);
        keys = 16'h0;
        cycles(150);
        n_compared++; if (kv_count - base != 2) begin n_mismatched++; $display("[TB] FAIL repeat_strobes: got %0d expected 2", kv_count - base); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_digit_entry();
        test_multi_key();
        test_reset_mid_debounce();
        test_random();
`ifdef SM_KEYPAD_REPEAT_EN
        test_repeat();
`endif
        n_compared++; if (kv_double != 0) begin n_mismatched++; $display("[TB] FAIL kv_consecutive: got %0d double strobes expected 0", kv_double); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
